// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch (if_*) and load/store (d_*) requesters.
// Optional macro ARB_RR_EN selects round-robin arbitration instead of data priority with a starvation guard.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = `ADDR_WIDTH,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    // state | meaning
    // IDLE  | grant the winning requester; writes complete here and stay in IDLE
    // WAIT  | one read outstanding; cnt counts the cycles left until rdata is valid
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic OWN_DATA  = 1'b0;
    localparam logic OWN_FETCH = 1'b1;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       owner;
    logic       fetch_win;
    logic       grant_if, grant_d;
    logic       rd_done;

`ifdef ARB_RR_EN
    logic last_grant;

    assign fetch_win = if_req && (!d_req || last_grant == OWN_DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWN_DATA;
        end else if (grant_if) begin
            last_grant <= OWN_FETCH;
        end else if (grant_d) begin
            last_grant <= OWN_DATA;
        end
    end
`else
    logic [3:0] starve_cnt;

    assign fetch_win = if_req && (!d_req || starve_cnt == 4'(STARVE_LIMIT));

    // Counts data grants made while fetch waits; saturates at the limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req && starve_cnt != 4'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= OWN_DATA;
        end else begin
            state <= state_nxt;
            // Loaded with latency-1 so that rvalid lands exactly MEM_LATENCY cycles after the grant
            if (state == IDLE && state_nxt == WAIT) begin
                cnt   <= 4'(MEM_LATENCY - 1);
                owner <= grant_if ? OWN_FETCH : OWN_DATA;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_if || (grant_d && !d_we)) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are gated by reset_n so nothing is granted while reset is held
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE && reset_n) begin
            grant_if = fetch_win;
            grant_d  = d_req && !fetch_win;
        end
    end

    assign rd_done = (state == WAIT) && (cnt == '0);

    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        mem_en    = grant_if || grant_d;
        mem_we    = grant_d && d_we;
        mem_addr  = '0;
        if (grant_if) begin
            mem_addr = if_addr;
        end else if (grant_d) begin
            mem_addr = d_addr;
        end
        mem_wdata = mem_we ? d_wdata : '0;
        mem_wstrb = mem_we ? d_wstrb : '0;
        if_rvalid = rd_done && owner == OWN_FETCH;
        d_rvalid  = rd_done && owner == OWN_DATA;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a cycle-indexed reference model predicts grant and
// rvalid events into a queue; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int LAT = 3;
    localparam int LIM = 4;

    localparam int K_IFG = 0;
    localparam int K_DG  = 1;
    localparam int K_IFR = 2;
    localparam int K_DR  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [3:0]    d_wstrb = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 4) return 32'h0050_0093;
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [3:0] st);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Memory responder: data for a read accepted in cycle T is presented in cycle T+LAT, junk otherwise
    logic [DW-1:0]  rmem [256];
    logic [DW-1:0]  pd [LAT];
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0]  junk = '0;
    logic           loaded = 1'b0;

    always @(posedge clk) begin
        junk  <= $urandom;
        pv    <= {pv[LAT-2:0], mem_en & ~mem_we};
        pd[0] <= rmem[mem_addr[9:2]];
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
        if (!loaded) begin
            for (int i = 0; i < 256; i++) rmem[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (mem_en && mem_we) begin
            rmem[mem_addr[9:2]] <= merge(rmem[mem_addr[9:2]], mem_wdata, mem_wstrb);
        end
    end

    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : junk;

    typedef struct {
        int            cyc;
        int            kind;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        logic [DW-1:0] rdata;
    } ev_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
    } dreq_t;

    ev_t           sbq[$];
    dreq_t         dq[$];
    logic [AW-1:0] fq[$];
    int            tests = 0;
    int            fails = 0;

    // Reference model state: memory image, when the pending read returns, who owns it
    logic [DW-1:0] mmem [256];
    int            rv_cyc = -1;
    int            starve = 0;
    logic          last_f = 1'b0;
    logic          own_f = 1'b0;
    logic [DW-1:0] rd_exp = '0;
    logic          m_if_g = 1'b0;
    logic          m_d_g = 1'b0;
    bit            rand_mode = 1'b0;

    function automatic ev_t mk_ev(input int k, input logic [AW-1:0] a, input logic w,
                                  input logic [DW-1:0] wd, input logic [3:0] st, input logic [DW-1:0] rd);
        ev_t e;
        e.cyc = cyc; e.kind = k; e.addr = a; e.we = w; e.wdata = wd; e.wstrb = st; e.rdata = rd;
        return e;
    endfunction

    task automatic model();
        logic fw;
        if (cyc == rv_cyc) begin
            sbq.push_back(mk_ev(own_f ? K_IFR : K_DR, '0, 1'b0, '0, '0, rd_exp));
        end else if (cyc > rv_cyc) begin
`ifdef ARB_RR_EN
            fw = if_req && (!d_req || !last_f);
`else
            fw = if_req && (!d_req || starve == LIM);
`endif
            if (fw) begin
                sbq.push_back(mk_ev(K_IFG, if_addr, 1'b0, '0, '0, '0));
                rd_exp = mmem[if_addr[9:2]];
                rv_cyc = cyc + LAT;
                own_f  = 1'b1;
                starve = 0;
                last_f = 1'b1;
                m_if_g = 1'b1;
            end else if (d_req) begin
                if (d_we) begin
                    sbq.push_back(mk_ev(K_DG, d_addr, 1'b1, d_wdata, d_wstrb, '0));
                    mmem[d_addr[9:2]] = merge(mmem[d_addr[9:2]], d_wdata, d_wstrb);
                end else begin
                    sbq.push_back(mk_ev(K_DG, d_addr, 1'b0, '0, '0, '0));
                    rd_exp = mmem[d_addr[9:2]];
                    rv_cyc = cyc + LAT;
                    own_f  = 1'b0;
                end
                if (if_req && starve < LIM) starve++;
                last_f = 1'b0;
                m_d_g  = 1'b1;
            end
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 255) * 4);
    endfunction

    // One cycle: apply reset level, retire granted requests, present new ones, run the model
    task automatic step(input logic rst_val);
        dreq_t r;
        @(posedge clk);
        #1;
        reset_n = rst_val;
        if (m_if_g) if_req = 1'b0;
        if (m_d_g) d_req = 1'b0;
        m_if_g = 1'b0;
        m_d_g  = 1'b0;
        if (!if_req) begin
            if (fq.size() > 0) begin
                if_req = 1'b1; if_addr = fq.pop_front();
            end else if (rand_mode && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = rand_addr();
            end
        end
        if (!d_req) begin
            if (dq.size() > 0) begin
                r = dq.pop_front();
                d_req = 1'b1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata; d_wstrb = r.wstrb;
            end else if (rand_mode && $urandom_range(0, 1) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
                d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
            end
        end
        if (reset_n) begin
            model();
        end else begin
            rv_cyc = -1; starve = 0; last_f = 1'b0;
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((if_req || d_req || fq.size() > 0 || dq.size() > 0 || cyc <= rv_cyc) && n < bound) begin
            step(1'b1);
            n++;
        end
        tests++;
        if (n >= bound) begin
            fails++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
    endtask

    function automatic dreq_t mk_d(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                   input logic [3:0] st);
        dreq_t r;
        r.we = w; r.addr = a; r.wdata = wd; r.wstrb = st;
        return r;
    endfunction

    ev_t ob, ex;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                tests++;
                if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} != 6'b0 || if_rdata != '0 ||
                    d_rdata != '0 || mem_addr != '0 || mem_wdata != '0 || mem_wstrb != '0) begin
                    fails++;
                    $display("FAIL reset_outputs cyc=%0d: gnt=%b%b rvalid=%b%b mem_en=%b mem_addr=%h, required all 0",
                             cyc, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_addr);
                end
                continue;
            end
            tests++;
            if (if_gnt && d_gnt) begin
                fails++;
                $display("FAIL both_gnt cyc=%0d: if_gnt=1 d_gnt=1, required at most one", cyc);
            end
            tests++;
            if (mem_en != (if_gnt || d_gnt)) begin
                fails++;
                $display("FAIL mem_en cyc=%0d: got %b, required %b", cyc, mem_en, if_gnt || d_gnt);
            end
            tests++;
            if ((!if_rvalid && if_rdata != '0) || (!d_rvalid && d_rdata != '0)) begin
                fails++;
                $display("FAIL rdata_idle cyc=%0d: if_rdata=%h d_rdata=%h, required 0 without rvalid",
                         cyc, if_rdata, d_rdata);
            end
            if (!mem_en) begin
                tests++;
                if (mem_we || mem_addr != '0 || mem_wdata != '0 || mem_wstrb != '0) begin
                    fails++;
                    $display("FAIL mem_idle cyc=%0d: we=%b addr=%h wdata=%h wstrb=%b, required 0",
                             cyc, mem_we, mem_addr, mem_wdata, mem_wstrb);
                end
            end
            if (if_gnt || d_gnt || if_rvalid || d_rvalid) begin
                ob.cyc = cyc;
                if (if_gnt || d_gnt) begin
                    ob.kind = if_gnt ? K_IFG : K_DG;
                    ob.addr = mem_addr; ob.we = mem_we; ob.wdata = mem_wdata; ob.wstrb = mem_wstrb;
                    ob.rdata = '0;
                end else begin
                    ob.kind = if_rvalid ? K_IFR : K_DR;
                    ob.addr = '0; ob.we = 1'b0; ob.wdata = '0; ob.wstrb = '0;
                    ob.rdata = if_rvalid ? if_rdata : d_rdata;
                end
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event cyc=%0d: got kind=%0d addr=%h rdata=%h, required none",
                             cyc, ob.kind, ob.addr, ob.rdata);
                end else begin
                    ex = sbq.pop_front();
                    if (ob.cyc != ex.cyc || ob.kind != ex.kind || ob.addr != ex.addr || ob.we != ex.we ||
                        ob.wdata != ex.wdata || ob.wstrb != ex.wstrb || ob.rdata != ex.rdata) begin
                        fails++;
                        $display("FAIL event: got cyc=%0d kind=%0d addr=%h we=%b wdata=%h wstrb=%b rdata=%h, required cyc=%0d kind=%0d addr=%h we=%b wdata=%h wstrb=%b rdata=%h",
                                 ob.cyc, ob.kind, ob.addr, ob.we, ob.wdata, ob.wstrb, ob.rdata,
                                 ex.cyc, ex.kind, ex.addr, ex.we, ex.wdata, ex.wstrb, ex.rdata);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                ex = sbq.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_event cyc=%0d: got nothing, required kind=%0d addr=%h rdata=%h",
                         cyc, ex.kind, ex.addr, ex.rdata);
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 256; i++) mmem[i] = init_word(i);

        // Reset held with both requesters pending; first cycle after release grants the winner
        if_req = 1'b1; if_addr = 16'h0030;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        repeat (3) step(1'b0);
        step(1'b1);
        drain(40);

        // Fetch read of a known word, then two back-to-back data reads
        fq.push_back(16'h0010);
        drain(40);
        dq.push_back(mk_d(1'b0, 16'h0040, '0, '0));
        dq.push_back(mk_d(1'b0, 16'h0044, '0, '0));
        drain(40);

        // Three back-to-back partial writes, then read them back
        dq.push_back(mk_d(1'b1, 16'h0100, $urandom, 4'b0011));
        dq.push_back(mk_d(1'b1, 16'h0104, $urandom, 4'b0011));
        dq.push_back(mk_d(1'b1, 16'h0108, $urandom, 4'b0011));
        drain(40);
        fq.push_back(16'h0104);
        dq.push_back(mk_d(1'b0, 16'h0100, '0, '0));
        drain(40);

        // Sustained conflict of continuous reads from both sides
        for (int i = 0; i < 12; i++) begin
            fq.push_back(AW'(16'h0200 + i * 4));
            dq.push_back(mk_d(1'b0, AW'(16'h0300 + i * 4), '0, '0));
        end
        drain(200);

        // Reset one cycle into an outstanding read: the read is dropped, service resumes afterwards
        dq.push_back(mk_d(1'b0, 16'h0050, '0, '0));
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        dq.push_back(mk_d(1'b0, 16'h0054, '0, '0));
        fq.push_back(16'h0058);
        drain(40);

        // Random traffic
        rand_mode = 1'b1;
        repeat (400) step(1'b1);
        rand_mode = 1'b0;
        drain(100);
        repeat (2) step(1'b1);

        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: %0d events left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
